mem_bus_ctrl: RTL
=================

Name: mem_bus_ctrl

Overview:
- Bus controller between the 6502 core (`proc`) and the synchronous 64KB `memory_block`.
- Accepts one byte request at a time from the core using a valid/ready handshake.
- Drives registered enable, write-enable, address and write-data to the memory block, absorbs the memory's fixed read latency, and returns a one-cycle response pulse.
- Replaces the core's direct, unregistered connection to memory, so the core and memory can share one clock.

Parameters:
- READ_LATENCY, 1: cycles from the edge where memory samples mem_en until mem_dout is valid. Legal range 1..8.
- ROM_BASE, 16'hE000: lowest write-protected address. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request present
- req_write  in  1  1 = write, 0 = read
- req_addr  in  16  request address
- req_wdata  in  8  write data
- req_ready  out  1  controller can accept a request
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  8  read data; 8'h00 for writes
- wr_fault  out  1  pulses with rsp_valid when a write is dropped
- mem_en  out  1  memory enable (ena)
- mem_we  out  1  memory write enable (wea)
- mem_addr  out  16  memory address (addra)
- mem_din  out  8  memory write data (dina)
- mem_dout  in  8  memory read data (douta)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - req_ready = 1.
  - rsp_valid = 0, wr_fault = 0, mem_en = 0, mem_we = 0.
  - mem_addr = 16'h0000, mem_din = 8'h00, rsp_data = 8'h00.
  - state = IDLE, latency counter = 0.
- Acceptance: a request is accepted on the edge where req_valid and req_ready are both 1.
  - req_write, req_addr and req_wdata are captured on that edge; later changes are ignored.
  - The core holds req_valid until accepted.
- States:
  - IDLE: req_ready = 1. On accept, go to ISSUE.
  - ISSUE: exactly one cycle. mem_en = 1; mem_addr and mem_din come from the captured request; mem_we = captured write.
    - Write: go to RESP.
    - Read with READ_LATENCY = 1: go to CAPTURE.
    - Read with READ_LATENCY > 1: load counter with READ_LATENCY-1 and go to WAIT.
  - WAIT: mem_en = 0. Decrement the counter; when it reaches 1, go to CAPTURE.
  - CAPTURE: register mem_dout into rsp_data, then go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE. req_ready returns to 1 in the cycle after RESP.
- req_ready is 0 in every state except IDLE. There are no back-to-back accepts, so throughput is one request per response.
- Timing, with the request accepted at the end of cycle n:
  - mem_en is high only in cycle n+1.
  - mem_dout is valid in cycle n+1+READ_LATENCY.
  - Read: rsp_valid is high in cycle n+2+READ_LATENCY.
  - Write: mem_we is high only in cycle n+1; rsp_valid is high in cycle n+2 with rsp_data = 8'h00.
- Output holding:
  - mem_we is 0 in every state except ISSUE of a write.
  - mem_addr and mem_din hold their last value outside ISSUE.
  - rsp_data holds its value until the next CAPTURE or write RESP.
- The core accepts every response; there is no response back-pressure.
- Address 16'hFFFF and all other addresses are passed through unchanged; there is no wrap-around logic.
- Reset in any state:
  - Return to IDLE on the next edge.
  - Any in-flight response is discarded: no rsp_valid pulse.
  - A pending mem_en or mem_we is cleared in the same edge.

Optional Feature:
- Macro: MEM_BUS_ROM_PROTECT_EN.
- Defined:
  - A write with captured address >= ROM_BASE does not touch memory: mem_en = 0 and mem_we = 0 in ISSUE.
  - The response still occurs in cycle n+2, with rsp_data = 8'h00 and wr_fault = 1 in the same cycle as rsp_valid.
  - Reads are unaffected.
- Not defined: wr_fault is tied to 0, every write reaches memory, and ROM_BASE is ignored.

Test Plan:
1. Reset scenario: assert reset for 3 cycles mid-read (state WAIT, READ_LATENCY = 4) -> no rsp_valid; req_ready = 1, mem_en = 0 and mem_we = 0 on the first edge after reset.
2. Write then read, READ_LATENCY = 1:
   - Write 8'hA5 to 16'h0200: mem_we pulse in cycle n+1 with addra = 16'h0200, dina = 8'hA5; rsp_valid in cycle n+2.
   - Read 16'h0200: rsp_valid in cycle n+3 with rsp_data = 8'hA5.
3. READ_LATENCY = 3, read of preloaded 16'hFFFC = 8'h00 and 16'hFFFD = 8'h80: each rsp_valid arrives exactly 5 cycles after accept; data 8'h00 then 8'h80; req_ready = 0 throughout.
4. Request attributes changed after accept:
   - Change req_addr on the cycle after accept -> memory still sees the captured address.
   - Hold req_valid high continuously -> the next accept happens only after the rsp_valid cycle.
5. With MEM_BUS_ROM_PROTECT_EN and ROM_BASE = 16'hE000:
   - Write 8'h11 to 16'hE000 -> no mem_en; wr_fault = 1 with rsp_valid; a subsequent read of 16'hE000 returns the original contents.
   - Write to 16'hDFFF -> normal write; wr_fault = 0.
6. Without the macro: the same write to 16'hE000 reaches memory, and a readback returns 8'h11.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Registered valid/ready bus controller between the 6502 core and the synchronous 64KB memory block.
// Optional write protection above ROM_BASE is compiled in with `define MEM_BUS_ROM_PROTECT_EN.
module mem_bus_ctrl #(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [15:0] ROM_BASE     = 16'hE000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        wr_fault,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cap_write;
    logic             cap_prot;
    logic             accept_c;
    logic             prot_c;

    logic             ready_nxt;
    logic             rsp_valid_nxt;
    logic [7:0]       rsp_data_nxt;
    logic             wr_fault_nxt;
    logic             mem_en_nxt;
    logic             mem_we_nxt;
    logic [15:0]      mem_addr_nxt;
    logic [7:0]       mem_din_nxt;

    assign accept_c = req_valid && req_ready;

`ifdef MEM_BUS_ROM_PROTECT_EN
    assign prot_c = req_write && (req_addr >= ROM_BASE);
`else
    logic unused_rom_base;
    assign prot_c          = 1'b0;
    assign unused_rom_base = ^ROM_BASE;
`endif

    // State, latency counter and the attributes of the accepted request
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_prot  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && accept_c) begin
                cap_write <= req_write;
                cap_prot  <= prot_c;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept_c) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (cap_write) begin
                    state_nxt = RESP;
                end else if (READ_LATENCY <= 1) begin
                    state_nxt = CAPTURE;
                end else begin
                    cnt_nxt   = CNT_W'(READ_LATENCY - 1);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so their next values follow the state being entered
    always_comb begin
        ready_nxt     = (state_nxt == IDLE);
        rsp_valid_nxt = (state_nxt == RESP);
        rsp_data_nxt  = rsp_data;
        wr_fault_nxt  = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_din_nxt   = mem_din;
        if (state == IDLE && accept_c) begin
            mem_en_nxt   = !prot_c;
            mem_we_nxt   = req_write && !prot_c;
            mem_addr_nxt = req_addr;
            mem_din_nxt  = req_wdata;
        end
        if (state == CAPTURE) rsp_data_nxt = mem_dout;
        if (state == ISSUE && cap_write) begin
            rsp_data_nxt = 8'h00;
            wr_fault_nxt = cap_prot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            wr_fault  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_din   <= 8'h00;
        end else begin
            req_ready <= ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            wr_fault  <= wr_fault_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_din   <= mem_din_nxt;
        end
    end

endmodule
